ddr2_cmd_issuer: RTL and testbench

Controller-side command issue stage that sits directly upstream of the PHY and drives the DFI control fields (cke, cs_n, ras_n, cas_n, we_n, ba, addr, odt). It accepts abstract DRAM commands over a valid/ready handshake and tracks per-bank open/closed state. It enforces DDR2 inter-command timing, then encodes each command onto registered DFI outputs. Illegal commands are dropped and flagged.

---
 rtl/ddr2_ctrl_pkg.sv | 63 ++++++
 rtl/ddr2_bank_timer.sv | 62 ++++++
 rtl/ddr2_cmd_issuer.sv | 215 +++++++++++++++++++++
 tb/tb_ddr2_cmd_issuer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr2_ctrl_pkg.sv
// ddr2_ctrl_pkg
//   Shared definitions for the DDR2 command issue path: the abstract command
//   enum carried on req_cmd, the (ras_n,cas_n,we_n) encodings driven to the
//   DFI, default timing parameters and the width of the timing down-counters.
//   Default DRAM geometry macros are provided here when the build does not
//   define them.

`ifndef DRAM_CS_WIDTH
`define DRAM_CS_WIDTH 1
`endif
`ifndef DRAM_BA_WIDTH
`define DRAM_BA_WIDTH 3
`endif
`ifndef DRAM_ADDR_WIDTH
`define DRAM_ADDR_WIDTH 14
`endif

package ddr2_ctrl_pkg;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5,
        CMD_MRS = 3'd6
    } cmd_e;

    // {ras_n, cas_n, we_n}
    localparam logic [2:0] ENC_NOP = 3'b111;
    localparam logic [2:0] ENC_ACT = 3'b011;
    localparam logic [2:0] ENC_RD  = 3'b101;
    localparam logic [2:0] ENC_WR  = 3'b100;
    localparam logic [2:0] ENC_PRE = 3'b010;
    localparam logic [2:0] ENC_REF = 3'b001;
    localparam logic [2:0] ENC_MRS = 3'b000;

    localparam int DEF_T_CKE_INIT = 200;
    localparam int DEF_T_RCD      = 4;
    localparam int DEF_T_RP       = 4;
    localparam int DEF_T_RAS      = 12;
    localparam int DEF_T_RFC      = 26;
    localparam int DEF_T_CCD      = 2;
    localparam int DEF_T_MRD      = 2;
    localparam int DEF_ODT_LEN    = 4;

    // Wide enough for any of the inter-command timings above.
    localparam int CNT_W = 8;

    function automatic logic [2:0] cmd_enc(input logic [2:0] cmd);
        case (cmd)
            CMD_ACT: return ENC_ACT;
            CMD_RD:  return ENC_RD;
            CMD_WR:  return ENC_WR;
            CMD_PRE: return ENC_PRE;
            CMD_REF: return ENC_REF;
            CMD_MRS: return ENC_MRS;
            default: return ENC_NOP;
        endcase
    endfunction

endpackage

// File: rtl/ddr2_bank_timer.sv
// ddr2_bank_timer
//   Per-bank state: open flag plus the tRCD / tRAS / tRP down-counters.
//   A counter loaded with T-1 on the issue edge reads zero on the edge T
//   cycles later, so the dependent command lands exactly T DFI cycles after
//   the one that loaded it.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   act, pre            an ACT / PRE to this bank is issued this cycle
//   open                bank currently open
//   ready_act           tRP satisfied (ACT, and REF across all banks)
//   ready_rw            tRCD satisfied (RD/WR)
//   ready_pre           tRAS satisfied (PRE)

module ddr2_bank_timer
    import ddr2_ctrl_pkg::*;
#(
    parameter int T_RCD = DEF_T_RCD,
    parameter int T_RAS = DEF_T_RAS,
    parameter int T_RP  = DEF_T_RP
)(
    input  logic clk,
    input  logic rst_n,
    input  logic act,
    input  logic pre,
    output logic open,
    output logic ready_act,
    output logic ready_rw,
    output logic ready_pre
);

    logic [CNT_W-1:0] trcd, tras, trp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            open <= 1'b0;
            trcd <= '0;
            tras <= '0;
            trp  <= '0;
        end else begin
            if (act) begin
                open <= 1'b1;
                trcd <= CNT_W'(T_RCD - 1);
                tras <= CNT_W'(T_RAS - 1);
            end else begin
                if (trcd != '0) trcd <= trcd - 1'b1;
                if (tras != '0) tras <= tras - 1'b1;
            end
            // PRE to a closed bank is legal and still restarts tRP.
            if (pre) begin
                open <= 1'b0;
                trp  <= CNT_W'(T_RP - 1);
            end else if (trp != '0) begin
                trp <= trp - 1'b1;
            end
        end
    end

    assign ready_act = (trp  == '0);
    assign ready_rw  = (trcd == '0);
    assign ready_pre = (tras == '0);

endmodule

// File: rtl/ddr2_cmd_issuer.sv
// ddr2_cmd_issuer
//   Command issue stage in front of the PHY. Takes abstract DRAM commands on
//   a valid/ready handshake into a one-entry holding register, checks them
//   against bank state (illegal ones are dropped with a one-cycle
//   err_illegal pulse), waits out DDR2 timing, then drives the registered
//   DFI control fields for exactly one cycle. All other cycles carry NOP.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   req_valid/req_ready            request handshake
//   req_cmd/req_ba/req_addr        command, bank, row/col/MR value
//                                  (addr[10] on PRE = all banks)
//   dfi_cke, dfi_cs_n, dfi_ras_n,
//   dfi_cas_n, dfi_we_n, dfi_ba,
//   dfi_addr, dfi_odt              registered DFI control fields
//   bank_open                      per-bank open flags
//   err_illegal                    pulse when a request is dropped

module ddr2_cmd_issuer
    import ddr2_ctrl_pkg::*;
#(
    parameter int CS_W       = `DRAM_CS_WIDTH,
    parameter int BA_W       = `DRAM_BA_WIDTH,
    parameter int ADDR_W     = `DRAM_ADDR_WIDTH,
    parameter int T_CKE_INIT = DEF_T_CKE_INIT,
    parameter int T_RCD      = DEF_T_RCD,
    parameter int T_RP       = DEF_T_RP,
    parameter int T_RAS      = DEF_T_RAS,
    parameter int T_RFC      = DEF_T_RFC,
    parameter int T_CCD      = DEF_T_CCD,
    parameter int T_MRD      = DEF_T_MRD,
    parameter int ODT_LEN    = DEF_ODT_LEN
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_cmd,
    input  logic [BA_W-1:0]       req_ba,
    input  logic [ADDR_W-1:0]     req_addr,
    output logic                  dfi_cke,
    output logic [CS_W-1:0]       dfi_cs_n,
    output logic                  dfi_ras_n,
    output logic                  dfi_cas_n,
    output logic                  dfi_we_n,
    output logic [BA_W-1:0]       dfi_ba,
    output logic [ADDR_W-1:0]     dfi_addr,
    output logic                  dfi_odt,
    output logic [(2**BA_W)-1:0]  bank_open,
    output logic                  err_illegal
);

    localparam int NBANK  = 2**BA_W;
    localparam int INIT_W = $clog2(T_CKE_INIT + 1);
    localparam int ODT_W  = $clog2(ODT_LEN + 1);

    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]          state;
    logic [INIT_W-1:0]   init_cnt;
    logic                init_done;

    logic [2:0]          h_cmd;
    logic [BA_W-1:0]     h_ba;
    logic [ADDR_W-1:0]   h_addr;
    logic                hold_valid;

    logic [NBANK-1:0]    rdy_act, rdy_rw, rdy_pre, act_b, pre_b;
    logic [CNT_W-1:0]    tccd, trfc, tmrd;
    logic [ODT_W-1:0]    odt_cnt;

    logic                illegal, timing_ok, issue_now, drop, consume, accept;

    assign hold_valid = (state == ST_HOLD);
    assign init_done  = (state == ST_INIT) && (init_cnt == INIT_W'(T_CKE_INIT - 1));

    // Legality and timing of the held request.
    always_comb begin
        illegal   = 1'b0;
        timing_ok = 1'b0;
        case (h_cmd)
            CMD_NOP: timing_ok = 1'b1;
            CMD_ACT: begin
                illegal   = bank_open[h_ba];
                timing_ok = rdy_act[h_ba];
            end
            CMD_RD, CMD_WR: begin
                illegal   = !bank_open[h_ba];
                timing_ok = rdy_rw[h_ba] && (tccd == '0);
            end
            // PRE-all only waits on tRAS of banks that are actually open.
            CMD_PRE: timing_ok = h_addr[10] ? &(rdy_pre | ~bank_open) : rdy_pre[h_ba];
            CMD_REF: begin
                illegal   = |bank_open;
                timing_ok = &rdy_act;
            end
            CMD_MRS: begin
                illegal   = |bank_open;
                timing_ok = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        if (h_cmd != CMD_NOP)
            timing_ok = timing_ok && (trfc == '0) && (tmrd == '0);
    end

    assign issue_now = hold_valid && !illegal && timing_ok;
    assign drop      = hold_valid && illegal;
    assign consume   = issue_now || drop;
    assign req_ready = (state != ST_INIT) && (!hold_valid || consume);
    assign accept    = req_valid && req_ready;

    // FSM and holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_INIT;
            init_cnt <= '0;
            h_cmd    <= CMD_NOP;
            h_ba     <= '0;
            h_addr   <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (init_done) state <= ST_IDLE;
                    else           init_cnt <= init_cnt + 1'b1;
                end
                default: begin
                    if (accept) begin
                        state  <= ST_HOLD;
                        h_cmd  <= req_cmd;
                        h_ba   <= req_ba;
                        h_addr <= req_addr;
                    end else if (consume) begin
                        state  <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Per-bank timers.
    for (genvar i = 0; i < NBANK; i++) begin : g_bank
        assign act_b[i] = issue_now && (h_cmd == CMD_ACT) && (h_ba == BA_W'(i));
        assign pre_b[i] = issue_now && (h_cmd == CMD_PRE) && (h_addr[10] || (h_ba == BA_W'(i)));

        ddr2_bank_timer #(
            .T_RCD (T_RCD),
            .T_RAS (T_RAS),
            .T_RP  (T_RP)
        ) u_timer (
            .clk       (clk),
            .rst_n     (rst_n),
            .act       (act_b[i]),
            .pre       (pre_b[i]),
            .open      (bank_open[i]),
            .ready_act (rdy_act[i]),
            .ready_rw  (rdy_rw[i]),
            .ready_pre (rdy_pre[i])
        );
    end

    // Global timers and the ODT window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tccd    <= '0;
            trfc    <= '0;
            tmrd    <= '0;
            odt_cnt <= '0;
        end else begin
            if (issue_now && (h_cmd == CMD_RD || h_cmd == CMD_WR)) tccd <= CNT_W'(T_CCD - 1);
            else if (tccd != '0)                                   tccd <= tccd - 1'b1;

            if (issue_now && h_cmd == CMD_REF) trfc <= CNT_W'(T_RFC - 1);
            else if (trfc != '0)               trfc <= trfc - 1'b1;

            if (issue_now && h_cmd == CMD_MRS) tmrd <= CNT_W'(T_MRD - 1);
            else if (tmrd != '0)               tmrd <= tmrd - 1'b1;

            // A WR inside an active window restarts it.
            if (issue_now && h_cmd == CMD_WR) odt_cnt <= ODT_W'(ODT_LEN);
            else if (odt_cnt != '0)           odt_cnt <= odt_cnt - 1'b1;
        end
    end

    assign dfi_odt = (odt_cnt != '0);

    // Registered DFI command: one cycle of command, NOP otherwise; ba/addr
    // keep their last value across NOP cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dfi_cke     <= 1'b0;
            dfi_cs_n    <= '1;
            dfi_ras_n   <= 1'b1;
            dfi_cas_n   <= 1'b1;
            dfi_we_n    <= 1'b1;
            dfi_ba      <= '0;
            dfi_addr    <= '0;
            err_illegal <= 1'b0;
        end else begin
            err_illegal <= drop;
            {dfi_ras_n, dfi_cas_n, dfi_we_n} <= ENC_NOP;
            if (init_done) begin
                dfi_cke  <= 1'b1;
                dfi_cs_n <= '0;
            end
            if (issue_now && h_cmd != CMD_NOP) begin
                {dfi_ras_n, dfi_cas_n, dfi_we_n} <= cmd_enc(h_cmd);
                dfi_ba   <= h_ba;
                dfi_addr <= h_addr;
            end
        end
    end

endmodule

// File: tb/tb_ddr2_cmd_issuer.sv
// tb_ddr2_cmd_issuer
//   Request streams (directed prefix plus random tail) are scheduled up front
//   by a timeline model: for each request, the edge it is accepted and the
//   edge it issues are computed from "last ACT/PRE/RD-WR/REF/MRS time plus
//   the matching DDR2 timing". The resulting per-edge expectations are then
//   compared against the DUT every cycle. A second run resets mid-ODT.

module tb_ddr2_cmd_issuer;

    localparam int CS_W = 1, BA_W = 3, ADDR_W = 14, NB = 8;
    localparam int TCKE = 200, TRCD = 4, TRP = 4, TRAS = 12, TRFC = 26;
    localparam int TCCD = 2, TMRD = 2, ODTL = 4;
    localparam int C_NOP = 0, C_ACT = 1, C_RD = 2, C_WR = 3, C_PRE = 4, C_REF = 5, C_MRS = 6;
    localparam int MAXR = 200, MAXE = 7000;

    logic                clk = 1'b0, rst_n = 1'b0;
    logic                req_valid = 1'b0, req_ready;
    logic [2:0]          req_cmd = '0;
    logic [BA_W-1:0]     req_ba = '0;
    logic [ADDR_W-1:0]   req_addr = '0;
    logic                dfi_cke, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_odt, err_illegal;
    logic [CS_W-1:0]     dfi_cs_n;
    logic [BA_W-1:0]     dfi_ba;
    logic [ADDR_W-1:0]   dfi_addr;
    logic [NB-1:0]       bank_open;

    ddr2_cmd_issuer #(.CS_W(CS_W), .BA_W(BA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_ba(req_ba), .req_addr(req_addr),
        .dfi_cke(dfi_cke), .dfi_cs_n(dfi_cs_n), .dfi_ras_n(dfi_ras_n),
        .dfi_cas_n(dfi_cas_n), .dfi_we_n(dfi_we_n), .dfi_ba(dfi_ba),
        .dfi_addr(dfi_addr), .dfi_odt(dfi_odt), .bank_open(bank_open),
        .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    // Edges since reset release.
    int cyc;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0d got %0h exp %0h", tag, cyc, got, exp);
        end
    endtask

    // Request stream and per-edge expectations.
    int            r_cmd[MAXR], r_ba[MAXR], r_addr[MAXR], iss_edge[MAXR];
    int            nreq, last_e;
    int            e_iss[MAXE], e_ba[MAXE], e_addr[MAXE];
    logic [2:0]    e_cmd[MAXE];
    bit            e_err[MAXE], e_odt[MAXE], e_rdy[MAXE];
    logic [NB-1:0] e_open[MAXE], snap[MAXE];

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [2:0] enc(input int c);
        case (c)
            C_ACT: return 3'b011;
            C_RD:  return 3'b101;
            C_WR:  return 3'b100;
            C_PRE: return 3'b010;
            C_REF: return 3'b001;
            C_MRS: return 3'b000;
            default: return 3'b111;
        endcase
    endfunction

    function automatic void add(input int c, input int b, input int a);
        r_cmd[nreq] = c; r_ba[nreq] = b; r_addr[nreq] = a;
        nreq++;
    endfunction

    task automatic build();
        int l_act[NB], l_pre[NB];
        int l_rw, l_ref, l_mrs, acc, d, c, b, a, cur_ba, cur_addr;
        logic [NB-1:0] op, cur_op;
        bit ill, all;
        for (int e = 0; e < MAXE; e++) begin
            e_iss[e] = -1; e_err[e] = 0; e_odt[e] = 0; e_rdy[e] = 0;
        end
        for (int i = 0; i < NB; i++) begin l_act[i] = -1000; l_pre[i] = -1000; end
        l_rw = -1000; l_ref = -1000; l_mrs = -1000; op = '0;
        acc = TCKE + 1;
        for (int k = 0; k < nreq; k++) begin
            c = r_cmd[k]; b = r_ba[k]; a = r_addr[k];
            all = (a & 'h400) != 0;
            e_rdy[acc] = 1;
            ill = (c == C_ACT && op[b]) || ((c == C_RD || c == C_WR) && !op[b]) ||
                  ((c == C_REF || c == C_MRS) && op != '0) || (c > C_MRS);
            d = acc + 1;
            if (!ill && c != C_NOP) begin
                d = imax(d, imax(l_ref + TRFC, l_mrs + TMRD));
                case (c)
                    C_ACT: d = imax(d, l_pre[b] + TRP);
                    C_RD, C_WR: d = imax(d, imax(l_act[b] + TRCD, l_rw + TCCD));
                    C_PRE: for (int i = 0; i < NB; i++)
                               if (all ? op[i] : (i == b)) d = imax(d, l_act[i] + TRAS);
                    C_REF: for (int i = 0; i < NB; i++) d = imax(d, l_pre[i] + TRP);
                    default: ;
                endcase
                case (c)
                    C_ACT: begin op[b] = 1'b1; l_act[b] = d; end
                    C_RD:  l_rw = d;
                    C_WR:  begin l_rw = d; for (int j = 0; j < ODTL; j++) e_odt[d + j] = 1; end
                    C_PRE: for (int i = 0; i < NB; i++)
                               if (all || i == b) begin op[i] = 1'b0; l_pre[i] = d; end
                    C_REF: l_ref = d;
                    C_MRS: l_mrs = d;
                    default: ;
                endcase
                e_iss[d] = k;
                snap[d]  = op;
            end else if (ill) begin
                e_err[d] = 1;
            end
            iss_edge[k] = d;
            acc = d;
        end
        last_e = acc + 30;
        if (last_e >= MAXE - 2) begin
            $display("FAIL schedule too long %0d", last_e);
            $fatal(1);
        end
        cur_ba = 0; cur_addr = 0; cur_op = '0;
        for (int e = 0; e <= last_e; e++) begin
            e_cmd[e] = 3'b111;
            if (e_iss[e] >= 0) begin
                cur_ba   = r_ba[e_iss[e]];
                cur_addr = r_addr[e_iss[e]];
                cur_op   = snap[e];
                e_cmd[e] = enc(r_cmd[e_iss[e]]);
            end
            e_ba[e] = cur_ba; e_addr[e] = cur_addr; e_open[e] = cur_op;
        end
    endtask

    task automatic chk_cycle(input int e);
        chk("cke",  dfi_cke, (e >= TCKE) ? 1 : 0);
        chk("cs_n", dfi_cs_n, (e >= TCKE) ? 0 : 1);
        chk("cmd",  {dfi_ras_n, dfi_cas_n, dfi_we_n}, e_cmd[e]);
        chk("ba",   dfi_ba, e_ba[e]);
        chk("addr", dfi_addr, e_addr[e]);
        chk("odt",  dfi_odt, e_odt[e]);
        chk("err",  err_illegal, e_err[e]);
        chk("open", bank_open, e_open[e]);
    endtask

    task automatic run(input int abort_edge);
        int  ptr, e;
        bit  acc_f;
        req_valid = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cke", dfi_cke, 0);
        chk("rst_cs_n", dfi_cs_n, 1);
        chk("rst_cmd", {dfi_ras_n, dfi_cas_n, dfi_we_n}, 3'b111);
        chk("rst_ba_addr", {dfi_ba, dfi_addr}, 0);
        chk("rst_misc", {dfi_odt, err_illegal, req_ready}, 0);
        chk("rst_open", bank_open, 0);
        rst_n = 1'b1;
        ptr = 0; acc_f = 0;
        forever begin
            @(negedge clk);
            e = cyc;
            chk_cycle(e);
            if (e == abort_edge || e >= last_e) break;
            if (acc_f) ptr++;
            if (ptr < nreq) begin
                req_valid = 1'b1;
                req_cmd   = 3'(r_cmd[ptr]);
                req_ba    = BA_W'(r_ba[ptr]);
                req_addr  = ADDR_W'(r_addr[ptr]);
                chk("ready", req_ready, e_rdy[e + 1]);
            end else begin
                req_valid = 1'b0;
            end
            acc_f = req_valid && req_ready;
        end
        req_valid = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [NB-1:0] gop;
        int r, c, b;

        // Directed prefix.
        nreq = 0;
        add(C_ACT, 2, 'h123);
        add(C_RD,  2, 'h40);
        add(C_RD,  5, 'h10);   // closed bank: dropped
        add(C_ACT, 0, 'h7);
        add(C_RD,  0, 1);
        add(C_RD,  0, 2);
        add(C_RD,  0, 3);
        add(C_PRE, 0, 'h400);  // all banks
        add(C_REF, 0, 0);
        add(C_ACT, 0, 'h55);
        add(C_WR,  0, 'h20);
        add(C_NOP, 0, 0);
        add(C_PRE, 3, 0);      // closed bank: legal
        add(C_MRS, 0, 'h42);   // bank 0 open: dropped
        add(C_PRE, 0, 0);
        add(C_MRS, 1, 'h42);

        // Random tail; RD/WR biased toward banks open in program order.
        gop = '0;
        repeat (120) begin
            r = $urandom_range(0, 99);
            b = $urandom_range(0, NB - 1);
            c = (r < 20) ? C_ACT : (r < 40) ? C_RD : (r < 55) ? C_WR : (r < 70) ? C_PRE :
                (r < 78) ? C_REF : (r < 84) ? C_MRS : (r < 92) ? C_NOP : 7;
            if ((c == C_RD || c == C_WR) && gop != '0 && $urandom_range(0, 4) != 0)
                while (!gop[b]) b = (b + 1) % NB;
            r = $urandom_range(0, (1 << ADDR_W) - 1);
            if (c == C_PRE && $urandom_range(0, 2) == 0) r = r | 'h400;
            add(c, b, r);
            if (c == C_ACT && !gop[b]) gop[b] = 1'b1;
            if (c == C_PRE) begin
                if ((r & 'h400) != 0) gop = '0;
                else gop[b] = 1'b0;
            end
        end
        build();
        run(-1);

        // WR, then reset asserted while the ODT window is still open.
        nreq = 0;
        add(C_ACT, 1, 'hAA);
        add(C_WR,  1, 'h8);
        build();
        run(iss_edge[1] + 2);
        rst_n = 1'b0;
        #1;
        chk("mid_odt",  dfi_odt, 0);
        chk("mid_open", bank_open, 0);
        chk("mid_cke",  dfi_cke, 0);
        chk("mid_cs_n", dfi_cs_n, 1);
        chk("mid_rdy",  req_ready, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("reinit_cke", dfi_cke, 0);
        chk("reinit_rdy", req_ready, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
